// File: rtl/call_pkg.sv
// Shared types for the attendant-station call responder.
package call_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    SERVE = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// found scanning last+1, last+2, ... with wrap, so the room served last
// has the lowest priority.
module rr_pick #(
  parameter  int N_ROOMS = 4,
  localparam int IDX_W   = $clog2(N_ROOMS)
) (
  input  logic [N_ROOMS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan farthest offset first so the nearest set request overwrites it.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N_ROOMS; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_ROOMS]) begin
        grant_idx = IDX_W'((int'(last) + k) % N_ROOMS);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_responder.sv
// Attendant-station end of the room call-light interface.
// Picks one pending room call by round-robin, sounds the buzzer, then walks
// the attendant through ack and done before pulsing cancel to the room.
// Optional feature: define CALL_RESP_ESCALATE_EN to enable the unacknowledged
// alert timer driving escalate; otherwise escalate is tied low.
//
// state | meaning
// IDLE  | no call latched; scanning lights
// ALERT | buzzer on, waiting for ack (or call withdrawal)
// SERVE | attendant at the room, waiting for done
// CLEAR | one-cycle cancel pulse to the served room
module call_responder
  import call_pkg::*;
#(
  parameter  int N_ROOMS = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDX_W   = $clog2(N_ROOMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ROOMS-1:0] light,
  input  logic               ack,
  input  logic               done,
  output logic [N_ROOMS-1:0] cancel,
  output logic               buzzer,
  output logic               busy,
  output logic [IDX_W-1:0]   room,
  output logic               escalate
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] grant_idx;
  logic             any;

  rr_pick #(.N_ROOMS(N_ROOMS)) u_rr_pick (
    .req       (light),
    .last      (last),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; withdrawal in ALERT outranks ack.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (any) state_nxt = ALERT;
      ALERT: begin
        if (!light[room]) state_nxt = IDLE;
        else if (ack)     state_nxt = SERVE;
      end
      SERVE: if (done) state_nxt = CLEAR;
      CLEAR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted room on leaving IDLE; move the pointer only on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      room <= '0;
      last <= IDX_W'(N_ROOMS - 1);
    end else begin
      if (state == IDLE && any) room <= grant_idx;
      if (state == CLEAR)       last <= room;
    end
  end

  // Moore output decode.
  always_comb begin
    cancel = '0;
    if (state == CLEAR) cancel[room] = 1'b1;
    buzzer = (state == ALERT);
    busy   = (state != IDLE);
  end

`ifdef CALL_RESP_ESCALATE_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] alert_cnt;

  // Count full ALERT cycles, restarting on each entry and saturating at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alert_cnt <= '0;
    end else if (state != ALERT) begin
      alert_cnt <= '0;
    end else if (alert_cnt != CNT_W'(TIMEOUT)) begin
      alert_cnt <= alert_cnt + 1'b1;
    end
  end

  // Escalate only while still alerting, so it drops as soon as ALERT is left.
  always_comb begin
    escalate = (state == ALERT) && (alert_cnt == CNT_W'(TIMEOUT));
  end
`else
  assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_call_responder.sv
// Directed self-checking bench for call_responder (N_ROOMS=4, TIMEOUT=16).
module tb_call_responder;

  logic       clk;
  logic       rst_n;
  logic [3:0] light;
  logic       ack;
  logic       done;
  logic [3:0] cancel;
  logic       buzzer;
  logic       busy;
  logic [1:0] room;
  logic       escalate;

  int checks = 0;
  int errors = 0;

`ifdef CALL_RESP_ESCALATE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  call_responder #(.N_ROOMS(4), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .light    (light),
    .ack      (ack),
    .done     (done),
    .cancel   (cancel),
    .buzzer   (buzzer),
    .busy     (busy),
    .room     (room),
    .escalate (escalate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_cancel, input logic e_buzzer,
                            input logic e_busy, input logic [1:0] e_room);
    check({tag, ".cancel"}, 32'(cancel), 32'(e_cancel));
    check({tag, ".buzzer"}, 32'(buzzer), 32'(e_buzzer));
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
    check({tag, ".room"},   32'(room),   32'(e_room));
  endtask

  initial begin
    logic [1:0] rr_order [5];
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; light = 4'b0000; ack = 1'b0; done = 1'b0;
    tick(); tick();
    check_outs("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    check("reset.escalate", 32'(escalate), 32'd0);

    // Single call on room 0.
    rst_n = 1'b1;
    tick();
    light = 4'b0001;
    tick();
    check_outs("r0_alert", 4'b0000, 1'b1, 1'b1, 2'd0);
    ack = 1'b1;
    tick();
    check_outs("r0_serve", 4'b0000, 1'b0, 1'b1, 2'd0);
    ack = 1'b0; done = 1'b1;
    tick();
    check_outs("r0_clear", 4'b0001, 1'b0, 1'b1, 2'd0);
    done = 1'b0; light = 4'b0000;
    tick();
    check_outs("r0_idle", 4'b0000, 1'b0, 1'b0, 2'd0);

    // Round-robin from reset pointer with all calls held high.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; light = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs($sformatf("rr%0d_alert", i), 4'b0000, 1'b1, 1'b1, rr_order[i]);
      ack = 1'b1;
      tick();
      ack = 1'b0; done = 1'b1;
      tick();
      check_outs($sformatf("rr%0d_clear", i), 4'b0001 << rr_order[i], 1'b0, 1'b1, rr_order[i]);
      done = 1'b0;
      tick();
      check($sformatf("rr%0d_idle.busy", i), 32'(busy), 32'd0);
    end

    // Withdrawal of room 2 before ack; pointer stays at room 0.
    light = 4'b0100;
    tick();
    check_outs("wd_alert", 4'b0000, 1'b1, 1'b1, 2'd2);
    light = 4'b0000;
    tick();
    check_outs("wd_idle", 4'b0000, 1'b0, 1'b0, 2'd2);
    tick();
    check_outs("wd_idle2", 4'b0000, 1'b0, 1'b0, 2'd2);
    light = 4'b1100;
    tick();
    check_outs("wd_realert", 4'b0000, 1'b1, 1'b1, 2'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0; done = 1'b1;
    tick();
    check_outs("wd_clear", 4'b0100, 1'b0, 1'b1, 2'd2);
    done = 1'b0; light = 4'b1000;
    tick();

    // ack and done together in ALERT: only ack acts.
    tick();
    check_outs("ad_alert", 4'b0000, 1'b1, 1'b1, 2'd3);
    ack = 1'b1; done = 1'b1;
    tick();
    check_outs("ad_serve", 4'b0000, 1'b0, 1'b1, 2'd3);
    ack = 1'b0;
    tick();
    check_outs("ad_clear", 4'b1000, 1'b0, 1'b1, 2'd3);
    done = 1'b0;
    tick();
    check_outs("ad_idle", 4'b0000, 1'b0, 1'b0, 2'd3);

    // Reset during SERVE for room 3 (light still set).
    tick();
    check_outs("rs_alert", 4'b0000, 1'b1, 1'b1, 2'd3);
    ack = 1'b1;
    tick();
    check_outs("rs_serve", 4'b0000, 1'b0, 1'b1, 2'd3);
    ack = 1'b0; rst_n = 1'b0;
    tick();
    check_outs("rs_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    check_outs("rs_realert", 4'b0000, 1'b1, 1'b1, 2'd3);
    check("esc_c1", 32'(escalate), 32'd0);

    // Unacknowledged alert: escalate in the 17th ALERT cycle when enabled.
    for (int c = 2; c <= 17; c++) begin
      tick();
      check($sformatf("esc_c%0d", c), 32'(escalate), 32'(ESC_EN && (c == 17)));
    end
    check("esc_buzzer", 32'(buzzer), 32'd1);
    ack = 1'b1;
    tick();
    check("esc_after_ack", 32'(escalate), 32'd0);
    check_outs("esc_serve", 4'b0000, 1'b0, 1'b1, 2'd3);
    ack = 1'b0; done = 1'b1;
    tick();
    check_outs("esc_clear", 4'b1000, 1'b0, 1'b1, 2'd3);
    done = 1'b0; light = 4'b0000;
    tick();
    check_outs("final_idle", 4'b0000, 1'b0, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
